// File: rtl/onchip_ram_avmm.sv
// On-chip single-port RAM behind an Avalon-MM style slave port, with optional zero-fill after reset.
// Latency: read data returns READ_LATENCY (1 or 2) clken-high cycles after the accepting cycle.
// Backpressure: waitrequest is high while clearing (and in reset); clken=0 stalls everything.
//
// Ports:
//   clk, reset_n        - single rising-edge clock, asynchronous active-low reset
//   address             - word address; addresses >= DEPTH drop writes and read back zero
//   byteenable          - per-byte write lanes
//   chipselect/read/write/writedata - command inputs, accepted when ready and clken=1
//   clken               - global clock enable; freezes FSM, clear counter, memory and read pipe
//   readdata/readdatavalid - read response, readdata holds its last valid value otherwise
//   waitrequest         - high while the array is being cleared or reset is asserted
module onchip_ram_avmm #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 15,
   parameter int DEPTH          = 25000,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic                    clken,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH may equal 2^ADDR_WIDTH, so the range compare needs one extra bit.
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LP_LAST  = IDX_W'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [IDX_W-1:0]      r_clr_addr;
   logic [IDX_W-1:0]      w_clr_addr_nxt;
   logic                  w_waitreq;

   logic                  w_acc;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_in_rng;
   logic [IDX_W-1:0]      w_idx;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  r_s1_vld;
   logic [DATA_WIDTH-1:0] r_s1_dat;
   logic                  w_pipe_vld;
   logic [DATA_WIDTH-1:0] w_pipe_dat;
   logic                  w_rsp_vld;
   logic [DATA_WIDTH-1:0] r_last_dat;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      w_waitreq      = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_waitreq = 1'b1;
            if (clken) begin
               if (r_clr_addr == LP_LAST) begin
                  w_state_nxt    = ST_READY;
                  w_clr_addr_nxt = '0;
               end else begin
                  w_clr_addr_nxt = r_clr_addr + IDX_W'(1);
               end
            end
         end
         ST_READY: begin
            w_waitreq = 1'b0;
         end
      endcase
   end

   // With CLEAR_ON_RESET=0 the reset state is READY, so reset itself must raise waitrequest.
   assign waitrequest = w_waitreq | ~reset_n;

   // ---------------- command decode ----------------
   // reset_n gates acceptance so a READY-reset array cannot be written while in reset.
   assign w_acc    = reset_n & (r_state == ST_READY) & clken & chipselect & (read | write);
   assign w_wr_acc = w_acc & write;
   assign w_rd_acc = w_acc & read & ~write;   // write wins, no response for read+write
   assign w_in_rng = ({1'b0, address} < LP_DEPTH);
   assign w_idx    = address[IDX_W-1:0];

   // ---------------- storage and first read stage ----------------
   always_ff @(posedge clk) begin
      if (clken) begin
         if (r_state == ST_CLEAR) begin
            r_mem[r_clr_addr] <= '0;
         end else if (w_wr_acc && w_in_rng) begin
            for (int b = 0; b < NB; b++) begin
               if (byteenable[b]) begin
                  r_mem[w_idx][8*b +: 8] <= writedata[8*b +: 8];
               end
            end
         end
         if (w_rd_acc) begin
            r_s1_dat <= w_in_rng ? r_mem[w_idx] : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_vld <= 1'b0;
      end else if (clken) begin
         r_s1_vld <= w_rd_acc;
      end
   end

   // ---------------- optional second read stage ----------------
   generate
      if (READ_LATENCY >= 2) begin : g_rl2
         logic                  r_s2_vld;
         logic [DATA_WIDTH-1:0] r_s2_dat;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_s2_vld <= 1'b0;
            end else if (clken) begin
               r_s2_vld <= r_s1_vld;
            end
         end

         always_ff @(posedge clk) begin
            if (clken) begin
               r_s2_dat <= r_s1_dat;
            end
         end

         assign w_pipe_vld = r_s2_vld;
         assign w_pipe_dat = r_s2_dat;
      end else begin : g_rl1
         assign w_pipe_vld = r_s1_vld;
         assign w_pipe_dat = r_s1_dat;
      end
   endgenerate

   // ---------------- response output ----------------
   // A response sitting in the last stage is only presented in a clken-high cycle;
   // it leaves the pipe on that same edge, so it is seen exactly once.
   assign w_rsp_vld     = w_pipe_vld & clken;
   assign readdatavalid = w_rsp_vld;
   assign readdata      = w_rsp_vld ? w_pipe_dat : r_last_dat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_dat <= '0;
      end else if (w_rsp_vld) begin
         r_last_dat <= w_pipe_dat;
      end
   end

endmodule

// File: tb/tb_onchip_ram_avmm.sv
module tb_onchip_ram_avmm;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 16;
   localparam int RL    = 2;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] address = '0;
   logic [3:0]    byteenable = '0;
   logic          chipselect = 1'b0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [DW-1:0] writedata = '0;
   logic          clken = 1'b0;
   logic [DW-1:0] readdata;
   logic          readdatavalid;
   logic          waitrequest;

   onchip_ram_avmm #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .readdata(readdata), .readdatavalid(readdatavalid),
      .waitrequest(waitrequest)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Memory as a plain array, responses as a queue stamped with the clken-high
   // cycle number in which they are due.
   typedef struct { int due; logic [31:0] dat; } rsp_t;
   logic [31:0] m_mem [DEPTH];
   rsp_t        rq[$];
   int          m_ce_cnt = 0;
   logic        m_ready = 1'b0;
   int          m_clear_left = DEPTH;
   logic [31:0] m_last = '0;

   task automatic model_reset();
      rq.delete();
      m_ready      = 1'b0;
      m_clear_left = DEPTH;
      m_last       = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
   endtask

   // Drive one cycle's inputs (caller is at a negedge), check outputs, advance model.
   task automatic apply(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic ce);
      logic        exp_vld;
      logic [31:0] exp_dat;
      chipselect = cs; read = rd; write = wr; address = a;
      byteenable = be; writedata = wd; clken = ce;
      #1;
      exp_vld = 1'b0;
      exp_dat = m_last;
      if (ce) begin
         m_ce_cnt++;
         if (rq.size() > 0 && rq[0].due == m_ce_cnt) begin
            exp_vld = 1'b1;
            exp_dat = rq[0].dat;
            m_last  = rq[0].dat;
            void'(rq.pop_front());
         end
      end
      chk("waitrequest", {31'b0, waitrequest}, {31'b0, ~m_ready});
      chk("readdatavalid", {31'b0, readdatavalid}, {31'b0, exp_vld});
      chk("readdata", readdata, exp_dat);
      if (ce) begin
         if (!m_ready) begin
            m_clear_left--;
            if (m_clear_left == 0) m_ready = 1'b1;
         end else if (cs && (rd || wr)) begin
            if (wr) begin
               if (int'(a) < DEPTH) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) m_mem[a][8*b +: 8] = wd[8*b +: 8];
               end
            end else begin
               rq.push_back('{due: m_ce_cnt + RL,
                              dat: (int'(a) < DEPTH) ? m_mem[a] : 32'h0});
            end
         end
      end
   endtask

   task automatic step(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic ce);
      @(negedge clk);
      apply(cs, rd, wr, a, be, wd, ce);
   endtask

   task automatic idle(input logic ce);
      step(L, L, L, '0, '0, '0, ce);
   endtask

   // Assert reset at a negedge, check the asynchronous reset values, hold, then
   // release and run the release cycle through the model.
   task automatic do_reset(input int hold);
      @(negedge clk);
      reset_n = 1'b0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
      #1;
      model_reset();
      chk("rst_waitrequest", {31'b0, waitrequest}, 32'd1);
      chk("rst_readdatavalid", {31'b0, readdatavalid}, 32'd0);
      chk("rst_readdata", readdata, 32'd0);
      repeat (hold) begin
         @(negedge clk);
         #1;
         chk("rst_hold_vld", {31'b0, readdatavalid}, 32'd0);
         chk("rst_hold_wait", {31'b0, waitrequest}, 32'd1);
      end
      @(negedge clk);
      reset_n = 1'b1;
      apply(L, L, L, '0, '0, '0, H);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic cs, rd, wr, ce;
      logic [AW-1:0] a;
      logic [3:0]    be;
      logic [31:0]   wd;
      logic          ev;
      logic [31:0]   ed;
   } vec_t;
   vec_t tv[$];

   function automatic vec_t mk(input logic cs, input logic rd, input logic wr, input logic [AW-1:0] a,
                               input logic [3:0] be, input logic [31:0] wd,
                               input logic ev, input logic [31:0] ed);
      vec_t v;
      v.cs = cs; v.rd = rd; v.wr = wr; v.ce = 1'b1; v.a = a; v.be = be; v.wd = wd;
      v.ev = ev; v.ed = ed;
      return v;
   endfunction

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      int wcnt;
      int vcnt;
      int pulses;
      logic [31:0] pdat;

      // Byte enables, back-to-back reads at latency 2, write-then-read,
      // out-of-range accesses, read+write collision, byteenable=0, unselected read.
      tv.push_back(mk(H, L, H, 5'd3,  4'hF, 32'hAABBCCDD, L, 32'h0));
      tv.push_back(mk(H, L, H, 5'd3,  4'h5, 32'h11223344, L, 32'h0));
      tv.push_back(mk(H, L, H, 5'd0,  4'hF, 32'd5,        L, 32'h0));
      tv.push_back(mk(H, L, H, 5'd1,  4'hF, 32'd6,        L, 32'h0));
      tv.push_back(mk(H, L, H, 5'd2,  4'hF, 32'd7,        L, 32'h0));
      tv.push_back(mk(H, H, L, 5'd3,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(H, H, L, 5'd0,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(H, H, L, 5'd1,  4'h0, 32'h0,        H, 32'hAA22CC44));
      tv.push_back(mk(H, H, L, 5'd2,  4'h0, 32'h0,        H, 32'd5));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        H, 32'd6));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        H, 32'd7));
      tv.push_back(mk(H, L, H, 5'd9,  4'hF, 32'h12345678, L, 32'd7));
      tv.push_back(mk(H, H, L, 5'd9,  4'h0, 32'h0,        L, 32'd7));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'd7));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        H, 32'h12345678));
      tv.push_back(mk(H, H, L, 5'd20, 4'h0, 32'h0,        L, 32'h12345678));
      tv.push_back(mk(H, L, H, 5'd20, 4'hF, 32'hFFFFFFFF, L, 32'h12345678));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        H, 32'h0));
      tv.push_back(mk(H, H, H, 5'd4,  4'hF, 32'hDEADBEEF, L, 32'h0));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(H, H, L, 5'd4,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(H, L, H, 5'd5,  4'h0, 32'h00000055, L, 32'h0));
      tv.push_back(mk(H, H, L, 5'd5,  4'h0, 32'h0,        H, 32'hDEADBEEF));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'hDEADBEEF));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        H, 32'h0));
      tv.push_back(mk(L, H, L, 5'd4,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'h0));
      tv.push_back(mk(L, L, L, 5'd0,  4'h0, 32'h0,        L, 32'h0));

      // ---- reset and full clear ----
      do_reset(2);
      wcnt = waitrequest ? 1 : 0;
      for (int g = 0; g < 40 && waitrequest; g++) begin
         idle(H);
         if (waitrequest) wcnt++;
      end
      chk("clear_cycles", wcnt, 32'd16);
      for (int i = 0; i < DEPTH; i++) step(H, H, L, AW'(i), 4'h0, 32'h0, H);
      repeat (3) idle(H);

      // ---- directed table ----
      foreach (tv[i]) begin
         step(tv[i].cs, tv[i].rd, tv[i].wr, tv[i].a, tv[i].be, tv[i].wd, tv[i].ce);
         chk($sformatf("tbl%0d_vld", i), {31'b0, readdatavalid}, {31'b0, tv[i].ev});
         chk($sformatf("tbl%0d_dat", i), readdata, tv[i].ed);
      end

      // ---- clken stall on a pending response ----
      step(H, L, H, 5'd2, 4'hF, 32'h0000CAFE, H);
      step(H, H, L, 5'd2, 4'h0, 32'h0, H);
      idle(H);
      vcnt = 0;
      step(H, H, L, 5'd0, 4'h0, 32'h0, L);   // must not be accepted
      if (readdatavalid) vcnt++;
      repeat (2) begin
         idle(L);
         if (readdatavalid) vcnt++;
      end
      chk("stall_vld_during", vcnt, 32'd0);
      pulses = 0;
      pdat = '0;
      repeat (4) begin
         idle(H);
         if (readdatavalid) begin
            pulses++;
            pdat = readdata;
         end
      end
      chk("stall_pulses", pulses, 32'd1);
      chk("stall_data", pdat, 32'h0000CAFE);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 600; i++) begin
         logic cs, rd, wr, ce;
         logic [AW-1:0] a;
         cs = ($urandom_range(9, 0) < 8);
         rd = 1'($urandom_range(1, 0));
         wr = 1'($urandom_range(1, 0));
         ce = ($urandom_range(99, 0) < 85);
         a  = AW'($urandom_range(19, 0));
         step(cs, rd, wr, a, 4'($urandom), $urandom, ce);
      end
      repeat (4) idle(H);

      // ---- reset with a read in flight, then reset mid-clear ----
      step(H, L, H, 5'd6, 4'hF, 32'h00001234, H);
      step(H, H, L, 5'd1, 4'h0, 32'h0, H);
      do_reset(2);
      vcnt = readdatavalid ? 1 : 0;
      repeat (6) begin
         idle(H);
         if (readdatavalid) vcnt++;
      end
      do_reset(1);
      wcnt = waitrequest ? 1 : 0;
      if (readdatavalid) vcnt++;
      for (int g = 0; g < 40 && waitrequest; g++) begin
         idle(H);
         if (waitrequest) wcnt++;
         if (readdatavalid) vcnt++;
      end
      chk("reclear_cycles", wcnt, 32'd16);
      chk("rst_discard_vld", vcnt, 32'd0);
      step(H, H, L, 5'd6, 4'h0, 32'h0, H);
      idle(H);
      idle(H);
      chk("reclear_vld", {31'b0, readdatavalid}, 32'd1);
      chk("reclear_dat", readdata, 32'h0);
      repeat (3) idle(H);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/onchip_ram_avmm.md
ONCHIP_RAM_AVMM -- requirements
Module: onchip_ram_avmm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; multiple of 8, 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, word-address width.
REQ-003 SHALL have parameter DEPTH, default 25000, number of words; 2..2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, read pipeline depth; legal values 1 or 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the whole array after reset when 1.
REQ-006 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port address  input  ADDR_WIDTH  word address.
REQ-009 SHALL have port byteenable  input  DATA_WIDTH/8  write byte lanes.
REQ-010 SHALL have port chipselect  input  1  slave select.
REQ-011 SHALL have port read  input  1  read request.
REQ-012 SHALL have port write  input  1  write request.
REQ-013 SHALL have port writedata  input  DATA_WIDTH  write data.
REQ-014 SHALL have port clken  input  1  global clock enable.
REQ-015 SHALL have port readdata  output  DATA_WIDTH  read data.
REQ-016 SHALL have port readdatavalid  output  1  one-cycle qualifier for readdata.
REQ-017 SHALL have port waitrequest  output  1  slave busy; commands are not accepted while high.

Function
REQ-018 SHALL implement a control FSM with two states: CLEAR and READY.
REQ-019 SHALL leave reset in CLEAR when CLEAR_ON_RESET=1, else in READY.
REQ-020 SHALL, in CLEAR, write all-zero words to addresses 0..DEPTH-1, one per clken-high cycle, ascending, then enter READY on the cycle after writing DEPTH-1.
REQ-021 SHALL drive waitrequest=1 in CLEAR and 0 in READY.
REQ-022 SHALL accept a command in a cycle when all of these hold: READY, clken=1, chipselect=1, and read or write is 1.
REQ-023 SHALL, on an accepted write, update only the byte lanes whose byteenable bit is 1; byteenable=0 leaves the word unchanged.
REQ-024 SHALL, when read and write are both 1, perform the write only; no read response is generated.
REQ-025 SHALL drop writes with address >= DEPTH, and SHALL return all-zero data, with readdatavalid, for reads with address >= DEPTH.
REQ-026 SHALL assert readdatavalid for exactly one clken-high cycle, READ_LATENCY clken-high cycles after the accepting cycle.
REQ-027 SHALL support one accepted read per cycle, with responses returned in issue order.
REQ-028 SHALL return the newly written data for a read accepted in the cycle after a write to the same address; this is write-then-read coherence.
REQ-029 SHALL, when clken=0: freeze the FSM, clear counter, memory and read pipeline; accept no command; and force readdatavalid=0.
REQ-030 SHALL present a pending response, stalled by clken=0, on the first subsequent clken-high cycle, exactly once.
REQ-031 SHALL hold readdata at its last valid value while readdatavalid=0.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force: readdata=0, readdatavalid=0, waitrequest=1, the read pipeline empty and the clear counter 0.
REQ-033 SHALL, when reset_n asserts during CLEAR, restart the clear at address 0 after release.
REQ-034 SHALL, when reset_n asserts during READY, discard all in-flight reads with no readdatavalid; memory contents are then re-cleared if CLEAR_ON_RESET=1, else retained.

Verification
REQ-035 SHALL verify clear: DEPTH=16, CLEAR_ON_RESET=1, release reset with clken=1 -> waitrequest high exactly 16 cycles; a read of each address 0..15 then returns 0.
REQ-036 SHALL verify byte-enable write: write 0xAABBCCDD to address 3 with byteenable=4'b1111, then 0x11223344 with byteenable=4'b0101 -> a read of address 3 returns 0xAA22CC44.
REQ-037 SHALL verify back-to-back reads at READ_LATENCY=2: reads of addresses 0,1,2 in consecutive cycles, holding 5,6,7 -> readdatavalid high in cycles 3,4,5 with data 5,6,7.
REQ-038 SHALL verify write-then-read: write 0x12345678 to address 9, read address 9 on the next cycle -> readdata=0x12345678 after READ_LATENCY cycles.
REQ-039 SHALL verify the clken stall: issue a read of address 2 (holding 0xCAFE), drop clken for 3 cycles before the response -> readdatavalid stays 0 during the stall, then a single pulse with 0xCAFE.
REQ-040 SHALL verify reset mid-operation: assert reset_n=0 at clear address 7, then release -> waitrequest high for a full DEPTH cycles; reset during an outstanding read -> no readdatavalid.
